// File: rtl/pio_cmd_responder_if.sv
// HPS PIO command/status words plus the command/response handshake to the coprocessor core.
// The responder uses the slave view; the HPS/core side uses the master view.
interface pio_cmd_responder_if;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [10:0] cmd_addr;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_error;

  modport slave (
    input  data_in, cmd_ready, rsp_valid, rsp_data, rsp_error,
    output data_out, cmd_valid, cmd_opcode, cmd_addr, cmd_data
  );

  modport master (
    output data_in, cmd_ready, rsp_valid, rsp_data, rsp_error,
    input  data_out, cmd_valid, cmd_opcode, cmd_addr, cmd_data
  );
endinterface

// File: rtl/pio_cmd_responder.sv
// Bridges an HPS PIO command word to a valid/ready coprocessor command and reports
// completion, error, timeout and overrun back through a sticky status word.
module pio_cmd_responder #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                clk,
  input logic                reset,
  pio_cmd_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [31:0] in_q;
  logic        start_prev;
  logic        armed;
  logic [15:0] tmo_cnt;

  logic        cmd_valid_q;
  logic [3:0]  cmd_opcode_q;
  logic [10:0] cmd_addr_q;
  logic [15:0] cmd_data_q;

  logic        done_q;
  logic        busy_q;
  logic        error_q;
  logic        timeout_q;
  logic        overrun_q;
  logic [3:0]  op_echo_q;
  logic [15:0] result_q;

  logic start_edge;
  assign start_edge = in_q[31] & ~start_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      in_q         <= '0;
      start_prev   <= 1'b0;
      armed        <= 1'b0;
      tmo_cnt      <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_opcode_q <= '0;
      cmd_addr_q   <= '0;
      cmd_data_q   <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
      op_echo_q    <= '0;
      result_q     <= '0;
    end else begin
      in_q  <= bus.data_in;
      // First cycle after reset loads start_prev from the raw input so a start
      // held high through release is not mistaken for a new edge.
      start_prev <= armed ? in_q[31] : bus.data_in[31];
      armed      <= 1'b1;

      case (state)
        IDLE: begin
          if (start_edge) begin
            op_echo_q <= in_q[30:27];
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
            result_q  <= '0;
            if (!in_q[30]) begin
              cmd_opcode_q <= in_q[30:27];
              cmd_addr_q   <= in_q[26:16];
              cmd_data_q   <= in_q[15:0];
              cmd_valid_q  <= 1'b1;
              busy_q       <= 1'b1;
              done_q       <= 1'b0;
              error_q      <= 1'b0;
              tmo_cnt      <= '0;
              state        <= ISSUE;
            end else begin
              done_q  <= 1'b1;
              error_q <= 1'b1;
            end
          end
        end

        ISSUE, WAIT: begin
          if (start_edge) begin
            overrun_q <= 1'b1;
          end
          // A response arriving on the final allowed cycle still completes normally.
          if (state == WAIT && bus.rsp_valid) begin
            result_q <= bus.rsp_data;
            error_q  <= bus.rsp_error;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            error_q     <= 1'b1;
            timeout_q   <= 1'b1;
            result_q    <= '0;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
            if (state == ISSUE && bus.cmd_ready) begin
              cmd_valid_q <= 1'b0;
              state       <= WAIT;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.cmd_opcode = cmd_opcode_q;
  assign bus.cmd_addr   = cmd_addr_q;
  assign bus.cmd_data   = cmd_data_q;
  assign bus.data_out   = {done_q, busy_q, error_q, timeout_q, overrun_q,
                           op_echo_q, 7'd0, result_q};

endmodule

// File: doc/pio_cmd_responder.md
PIO_CMD_RESPONDER -- requirements
Module: pio_cmd_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: cycles allowed in ISSUE+WAIT before abort (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port data_in  input  32  command word from HPS PIO: [31] start, [30:27] opcode, [26:16] addr, [15:0] data.
REQ-005 SHALL have port data_out  output  32  status word to HPS PIO: [31] done, [30] busy, [29] error, [28] timeout, [27] overrun, [26:23] opcode echo, [22:16] zero, [15:0] result.
REQ-006 SHALL have port cmd_valid  output  1  command to coprocessor core valid.
REQ-007 SHALL have port cmd_ready  input  1  core accepts command.
REQ-008 SHALL have port cmd_opcode  output  4  latched opcode.
REQ-009 SHALL have port cmd_addr  output  11  latched addr.
REQ-010 SHALL have port cmd_data  output  16  latched data.
REQ-011 SHALL have port rsp_valid  input  1  single-cycle core response strobe.
REQ-012 SHALL have port rsp_data  input  16  core result.
REQ-013 SHALL have port rsp_error  input  1  core reports failure.

Function
REQ-014 SHALL register data_in into in_q every cycle; start edge = in_q[31] & ~start_prev, start_prev = in_q[31] delayed one cycle.
REQ-015 SHALL implement states IDLE, ISSUE, WAIT.
REQ-016 IDLE + start edge + opcode 0..7: SHALL latch opcode/addr/data onto cmd_* and clear done/error/timeout/overrun/result; go to ISSUE; busy=1.
REQ-017 IDLE + start edge + opcode 8..15: SHALL stay IDLE, never assert cmd_valid, set done=1, error=1, timeout=0, result=0, opcode echo = opcode.
REQ-018 Latency: data_in[31] rises before edge k -> edge detected in cycle k+1 -> busy and cmd_valid high in cycle k+2.
REQ-019 ISSUE: cmd_valid=1, cmd_* stable; cmd_valid&cmd_ready -> WAIT next cycle, cmd_valid=0.
REQ-020 WAIT: rsp_valid -> result=rsp_data, error=rsp_error, done=1, busy=0, IDLE next cycle.
REQ-021 rsp_valid SHALL be ignored in IDLE and ISSUE.
REQ-022 16-bit timeout counter SHALL clear on ISSUE entry and increment each ISSUE/WAIT cycle; reaching TIMEOUT_CYCLES-1 without completion -> IDLE, cmd_valid=0, done=1, error=1, timeout=1, result=0.
REQ-023 rsp_valid in the same cycle as the timeout SHALL win: normal completion, timeout=0.
REQ-024 Start edge in ISSUE/WAIT SHALL not be queued: set overrun=1; current op continues unaffected.
REQ-025 start falling mid-operation SHALL have no effect.
REQ-026 done, error, timeout, overrun, result, opcode echo SHALL be sticky until next accepted start edge (REQ-016/017).
REQ-027 data_out[22:16] SHALL always be 0; busy=1 exactly in ISSUE and WAIT.

Reset
REQ-028 On reset assertion, SHALL immediately enter IDLE and clear in_q, start_prev, counter, cmd_valid, cmd_*, data_out to 0.
REQ-029 Reset mid-operation SHALL abandon the command with no flag set; start held high through reset release SHALL NOT count as an edge (start_prev reloads first).

Verification
REQ-030 Normal: data_in=0x8A5A_1234 (op 1), cmd_ready=1, rsp_valid one cycle after accept with rsp_data=0xBEEF -> cmd_addr=0x25A, cmd_data=0x1234, data_out=0x8080_BEEF.
REQ-031 Backpressure: cmd_ready low 5 cycles -> cmd_valid held 6 cycles with stable cmd_*, busy=1 throughout, single handshake.
REQ-032 Illegal opcode: data_in=0xC000_0000 (op 8) -> no cmd_valid; data_out=0xA400_0000 two cycles after edge.
REQ-033 Timeout (TIMEOUT_CYCLES=8): cmd_ready=0 forever -> after 8 busy cycles data_out[31:28]=4'b1011, cmd_valid=0, late rsp_valid ignored.
REQ-034 Overrun: toggle start low/high while in WAIT -> data_out[27]=1 after completion, exactly one cmd_valid handshake.
REQ-035 Reset in WAIT with start high: after release no cmd_valid until start goes low then high again.
